// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request and registered result response between control and alu_seq.
interface alu_seq_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [3:0]      alucontrol;
   logic            valid_in;
   logic            ready_out;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            valid_out;
   modport master (output a, b, alucontrol, valid_in, input ready_out, result, zero, valid_out);
   modport slave  (input a, b, alucontrol, valid_in, output ready_out, result, zero, valid_out);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with single-cycle ops and XLEN-cycle mul/div.
// ALU_SEQ_MULDIV_EN builds MUL/MULHU/DIVU/REMU; without it those opcodes act as reserved.
module alu_seq #(
   parameter int XLEN = 32
) (
   input logic      clk,
   input logic      reset_n,
   alu_seq_if.slave bus
);
   localparam int SHW = $clog2(XLEN);
   logic [SHW-1:0]  w_shamt;
   logic [XLEN-1:0] w_alu;
   logic            w_accept;
   logic [XLEN-1:0] r_result;
   logic            r_valid;
   assign w_shamt    = bus.b[SHW-1:0];
   assign w_accept   = bus.valid_in & bus.ready_out;
   assign bus.result    = r_result;
   assign bus.zero      = ~|r_result;
   assign bus.valid_out = r_valid;
   always_comb begin
      case (bus.alucontrol)
         4'b0000: w_alu = bus.a + bus.b;
         4'b0001: w_alu = bus.a - bus.b;
         4'b0010: w_alu = bus.a & bus.b;
         4'b0011: w_alu = bus.a | bus.b;
         4'b0100: w_alu = bus.a ^ bus.b;
         4'b0101: w_alu = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
         4'b0110: w_alu = {{(XLEN-1){1'b0}}, bus.a < bus.b};
         4'b0111: w_alu = bus.a << w_shamt;
         4'b1000: w_alu = bus.a >> w_shamt;
         4'b1001: w_alu = $signed(bus.a) >>> w_shamt;
         default: w_alu = '0;
      endcase
   end
`ifdef ALU_SEQ_MULDIV_EN
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;
   logic [0:0]        r_state;
   logic [SHW-1:0]    r_cnt;
   logic [1:0]        r_op;
   logic [XLEN-1:0]   r_opnd;
   logic [2*XLEN-1:0] r_acc;
   logic              w_multi;
   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_trial;
   logic [2*XLEN-1:0] w_nxt;
   assign bus.ready_out = (r_state == S_IDLE);
   assign w_multi = (bus.alucontrol[3:1] == 3'b101) | (bus.alucontrol[3:1] == 3'b110);
   // r_acc is {product high, multiplier} for mul and {remainder, quotient} for div
   assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_trial = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {1'b0, r_opnd};
   assign w_nxt   = r_op[1] ? {w_sum, r_acc[XLEN-1:1]} :
                    w_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0} :
                    {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_op     <= '0;
         r_opnd   <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
      end else if (r_state == S_IDLE) begin
         r_valid <= w_accept & ~w_multi;
         if (w_accept & w_multi) begin
            r_state <= S_BUSY;
            r_cnt   <= SHW'(XLEN-1);
            r_op    <= bus.alucontrol[1:0];
            r_opnd  <= bus.alucontrol[1] ? bus.a : bus.b;
            r_acc   <= {{XLEN{1'b0}}, bus.alucontrol[1] ? bus.b : bus.a};
         end else if (w_accept) begin
            r_result <= w_alu;
         end
      end else begin
         r_acc   <= w_nxt;
         r_cnt   <= r_cnt - 1'b1;
         r_valid <= (r_cnt == '0);
         if (r_cnt == '0) begin
            r_state  <= S_IDLE;
            r_result <= r_op[0] ? w_nxt[2*XLEN-1:XLEN] : w_nxt[XLEN-1:0];
         end
      end
   end
`else
   assign bus.ready_out = 1'b1;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_result <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= w_accept;
         if (w_accept) r_result <= w_alu;
      end
   end
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq at XLEN=32.
module tb_alu_seq;
   localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010, OR_ = 4'b0011, XOR_ = 4'b0100;
   localparam logic [3:0] SLT = 4'b0101, SLTU = 4'b0110, SLL = 4'b0111, SRL = 4'b1000, SRA = 4'b1001;
   localparam logic [3:0] MUL = 4'b1010, MULHU = 4'b1011, DIVU = 4'b1100, REMU = 4'b1101, RSV = 4'b1110;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   alu_seq_if #(.XLEN(32)) bus ();
   alu_seq #(.XLEN(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.alucontrol = op;
      bus.a = a;
      bus.b = b;
      bus.valid_in = 1'b1;
   endtask
   task automatic test_reset();
      bus.valid_in = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.alucontrol = '0;
      #2 reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      n_vec++;
      if (bus.result !== 32'h0 || bus.zero !== 1'b1 || bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) begin
         n_err++;
         $display("FAIL reset: result=%h zero=%b valid_out=%b ready_out=%b want 0 1 0 1",
                  bus.result, bus.zero, bus.valid_out, bus.ready_out);
      end
      tick();
      n_vec++;
      if (bus.result !== 32'h0 || bus.valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: result=%h valid_out=%b want 0 0", bus.result, bus.valid_out);
      end
   endtask
   task automatic test_back_to_back();
      logic [3:0]  t_op  [12] = '{ADD, SUB, SLT, SLTU, SRA, AND_, OR_, XOR_, SLL, SRL, RSV, ADD};
      logic [31:0] t_a   [12] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h80000000, 32'h80000000, 32'hF0F0F0F0,
                                  32'hF0F0F0F0, 32'hAAAAAAAA, 32'h00000001, 32'h80000000, 32'h12345678, 32'h12345678};
      logic [31:0] t_b   [12] = '{32'h1, 32'd7, 32'h1, 32'h1, 32'h24, 32'hFF00FF00,
                                  32'h0F0F0000, 32'hFFFFFFFF, 32'h3F, 32'h1F, 32'h1, 32'h11111111};
      logic [31:0] t_exp [12] = '{32'h0, 32'hFFFFFFFE, 32'h1, 32'h0, 32'hF8000000, 32'hF000F000,
                                  32'hFFFFF0F0, 32'h55555555, 32'h80000000, 32'h00000001, 32'h0, 32'h23456789};
      for (int i = 0; i < 12; i++) begin
         drive(t_op[i], t_a[i], t_b[i]);
         tick();
         n_vec++;
         if (bus.result !== t_exp[i] || bus.zero !== (t_exp[i] == 0) || bus.valid_out !== 1'b1 || bus.ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL b2b[%0d] op=%b: result=%h zero=%b valid_out=%b ready_out=%b want %h %b 1 1",
                     i, t_op[i], bus.result, bus.zero, bus.valid_out, bus.ready_out, t_exp[i], t_exp[i] == 0);
         end
      end
      bus.valid_in = 1'b0;
      tick();
      n_vec++;
      if (bus.valid_out !== 1'b0 || bus.result !== 32'h23456789 || bus.zero !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_hold: valid_out=%b result=%h zero=%b want 0 23456789 0", bus.valid_out, bus.result, bus.zero);
      end
   endtask
`ifdef ALU_SEQ_MULDIV_EN
   task automatic run_multi(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input string nm);
      drive(op, a, b);
      tick();
      bus.valid_in = 1'b0;
      bus.a = 32'hDEADBEEF;
      bus.b = 32'h0;
      n_vec++;
      if (bus.ready_out !== 1'b0 || bus.valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL %s accept: ready_out=%b valid_out=%b want 0 0", nm, bus.ready_out, bus.valid_out);
      end
      for (int t = 1; t <= 32; t++) begin
         if (t == 5) drive(ADD, 32'd1, 32'd1);
         if (t == 6) bus.valid_in = 1'b0;
         tick();
         n_vec++;
         if (t < 32) begin
            if (bus.ready_out !== 1'b0 || bus.valid_out !== 1'b0) begin
               n_err++;
               $display("FAIL %s busy t=%0d: ready_out=%b valid_out=%b want 0 0", nm, t, bus.ready_out, bus.valid_out);
            end
         end else if (bus.valid_out !== 1'b1 || bus.ready_out !== 1'b1 || bus.result !== exp) begin
            n_err++;
            $display("FAIL %s done: valid_out=%b ready_out=%b result=%h want 1 1 %h",
                     nm, bus.valid_out, bus.ready_out, bus.result, exp);
         end
      end
      tick();
      n_vec++;
      if (bus.valid_out !== 1'b0 || bus.result !== exp) begin
         n_err++;
         $display("FAIL %s after: valid_out=%b result=%h want 0 %h", nm, bus.valid_out, bus.result, exp);
      end
   endtask
   task automatic test_mul();
      run_multi(MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_ones");
      run_multi(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ones");
      run_multi(MUL,   32'h00010000, 32'h00010001, 32'h00010000, "mul_lo");
      run_multi(MULHU, 32'h80000000, 32'h00000004, 32'h00000002, "mulhu_hi");
   endtask
   task automatic test_div();
      run_multi(DIVU, 32'd100, 32'd7, 32'd14,        "divu");
      run_multi(REMU, 32'd100, 32'd7, 32'd2,         "remu");
      run_multi(DIVU, 32'd123, 32'd0, 32'hFFFFFFFF,  "divu_by0");
      run_multi(REMU, 32'd123, 32'd0, 32'd123,       "remu_by0");
   endtask
`else
   task automatic test_no_muldiv();
      logic [3:0] ops [4] = '{MUL, MULHU, DIVU, REMU};
      for (int i = 0; i < 4; i++) begin
         drive(ADD, 32'd1, 32'd1);
         tick();
         drive(ops[i], 32'd3, 32'd4);
         tick();
         bus.valid_in = 1'b0;
         n_vec++;
         if (bus.result !== 32'h0 || bus.valid_out !== 1'b1 || bus.ready_out !== 1'b1 || bus.zero !== 1'b1) begin
            n_err++;
            $display("FAIL nomuldiv op=%b: result=%h valid_out=%b ready_out=%b zero=%b want 0 1 1 1",
                     ops[i], bus.result, bus.valid_out, bus.ready_out, bus.zero);
         end
      end
   endtask
`endif
   task automatic test_reset_mid();
      bool_seen_check: begin
         logic seen;
         seen = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
         drive(DIVU, 32'd100, 32'd7);
         tick();
         bus.valid_in = 1'b0;
         repeat (10) tick();
`else
         drive(ADD, 32'd7, 32'd0);
         tick();
         bus.valid_in = 1'b0;
`endif
         reset_n = 1'b0;
         #2;
         n_vec++;
         if (bus.result !== 32'h0 || bus.zero !== 1'b1 || bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: result=%h zero=%b valid_out=%b ready_out=%b want 0 1 0 1",
                     bus.result, bus.zero, bus.valid_out, bus.ready_out);
         end
         #2 reset_n = 1'b1;
         for (int t = 0; t < 40; t++) begin
            tick();
            if (bus.valid_out !== 1'b0) seen = 1'b1;
         end
         n_vec++;
         if (seen !== 1'b0 || bus.ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_discard: stray_valid=%b ready_out=%b want 0 1", seen, bus.ready_out);
         end
         drive(ADD, 32'd2, 32'd3);
         tick();
         bus.valid_in = 1'b0;
         n_vec++;
         if (bus.result !== 32'd5 || bus.valid_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_add: result=%h valid_out=%b want 5 1", bus.result, bus.valid_out);
         end
      end
   endtask
   initial begin
      test_reset();
      test_back_to_back();
`ifdef ALU_SEQ_MULDIV_EN
      test_mul();
      test_div();
`else
      test_no_muldiv();
`endif
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
